// File: rtl/wbu_rxarbiter_if.sv
// Byte-stream bundle between the two debug sources, the receive arbiter and
// the hex decoder.
interface wbu_rxarbiter_if;
  logic       i_a_stb;
  logic [7:0] i_a_byte;
  logic       o_a_busy;
  logic       i_b_stb;
  logic [7:0] i_b_byte;
  logic       o_b_busy;
  logic       o_stb;
  logic [7:0] o_byte;
  logic       i_busy;
  logic       o_owner;
  logic       o_locked;

  modport slave (
    input  i_a_stb, i_a_byte, i_b_stb, i_b_byte, i_busy,
    output o_a_busy, o_b_busy, o_stb, o_byte, o_owner, o_locked
  );

  modport master (
    output i_a_stb, i_a_byte, i_b_stb, i_b_byte, i_busy,
    input  o_a_busy, o_b_busy, o_stb, o_byte, o_owner, o_locked
  );
endinterface

// File: rtl/wbu_rxarbiter.sv
// Two-source receive arbiter for the debug bus: locks to one source per command
// line, releases on newline or idle timeout, and lets the other host preempt with ^C.
module wbu_rxarbiter #(
  parameter int TIMEOUT_BITS = 10
) (
  input logic            i_clk,
  input logic            i_reset_n,
  wbu_rxarbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOCK_A, LOCK_B} state_t;

  localparam logic [7:0]              NL      = 8'h0A;
  localparam logic [6:0]              SOFT    = 7'h03;
  localparam logic [TIMEOUT_BITS-1:0] CNT_MAX = '1;

  state_t                  state_q, state_d;
  logic                    owner_q, owner_d;
  logic                    last_owner_q, last_owner_d;
  logic [TIMEOUT_BITS-1:0] cnt_q, cnt_d;
  logic                    stb_q, locked_q;
  logic [7:0]              byte_q;
  logic                    out_ready, accept_a, accept_b;

  function automatic logic [TIMEOUT_BITS-1:0] sat_inc(input logic [TIMEOUT_BITS-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  assign out_ready = !stb_q || !bus.i_busy;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cnt_d        = '0;
    accept_a     = 1'b0;
    accept_b     = 1'b0;
    case (state_q)
      IDLE: begin
        // On a tie the source that did not own the previous line wins
        accept_a = out_ready && bus.i_a_stb && (!bus.i_b_stb || last_owner_q);
        accept_b = out_ready && bus.i_b_stb && (!bus.i_a_stb || !last_owner_q);
        if (accept_a) begin
          owner_d      = 1'b0;
          last_owner_d = 1'b0;
          if (bus.i_a_byte != NL) state_d = LOCK_A;
        end else if (accept_b) begin
          owner_d      = 1'b1;
          last_owner_d = 1'b1;
          if (bus.i_b_byte != NL) state_d = LOCK_B;
        end
      end
      LOCK_A: begin
        accept_b = out_ready && bus.i_b_stb && (bus.i_b_byte[6:0] == SOFT);
        accept_a = out_ready && bus.i_a_stb && !accept_b;
        if (accept_b) begin
          state_d      = LOCK_B;
          owner_d      = 1'b1;
          last_owner_d = 1'b1;
        end else if (accept_a) begin
          if (bus.i_a_byte == NL) state_d = IDLE;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      LOCK_B: begin
        accept_a = out_ready && bus.i_a_stb && (bus.i_a_byte[6:0] == SOFT);
        accept_b = out_ready && bus.i_b_stb && !accept_a;
        if (accept_a) begin
          state_d      = LOCK_A;
          owner_d      = 1'b0;
          last_owner_d = 1'b0;
        end else if (accept_b) begin
          if (bus.i_b_byte == NL) state_d = IDLE;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      cnt_q        <= '0;
      locked_q     <= 1'b0;
      stb_q        <= 1'b0;
      byte_q       <= 8'h00;
    end else begin
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
      locked_q     <= (state_d != IDLE);
      // Output register holds its byte while the decoder stalls
      if (out_ready) begin
        stb_q <= accept_a || accept_b;
        if (accept_a || accept_b) byte_q <= accept_a ? bus.i_a_byte : bus.i_b_byte;
      end
    end
  end

  assign bus.o_a_busy = !accept_a;
  assign bus.o_b_busy = !accept_b;
  assign bus.o_stb    = stb_q;
  assign bus.o_byte   = byte_q;
  assign bus.o_owner  = owner_q;
  assign bus.o_locked = locked_q;

endmodule

// File: tb/tb_wbu_rxarbiter.sv
// Scoreboard bench for wbu_rxarbiter: expected {owner,byte} pairs are queued as
// stimulus is planned and popped whenever the decoder side consumes a byte.
module tb_wbu_rxarbiter;

  logic i_clk = 1'b0;
  logic i_reset_n;
  wbu_rxarbiter_if bus();

  wbu_rxarbiter #(.TIMEOUT_BITS(10)) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .bus       (bus)
  );

  always #5 i_clk = ~i_clk;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [8:0] sb[$];
  logic [7:0] src_a[$];
  logic [7:0] src_b[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic expect_byte(input logic owner, input logic [7:0] b);
    sb.push_back({owner, b});
  endtask

  // Consumed bytes are those visible with the decoder not stalling
  always @(negedge i_clk) begin
    if (bus.o_stb === 1'b1 && bus.i_busy === 1'b0) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_byte", {24'h0, bus.o_byte}, 32'hFFFF_FFFF);
      end else begin
        logic [8:0] e;
        e = sb.pop_front();
        chk("sb_byte", {24'h0, bus.o_byte}, {24'h0, e[7:0]});
        chk("sb_owner", {31'h0, bus.o_owner}, {31'h0, e[8]});
      end
    end
  end

  task automatic run_streams(input bit chk_b_busy);
    int n = 0;
    bit acc_a, acc_b;
    while ((src_a.size() > 0 || src_b.size() > 0) && n < 200) begin
      bus.i_a_stb  = (src_a.size() > 0);
      bus.i_a_byte = (src_a.size() > 0) ? src_a[0] : 8'h00;
      bus.i_b_stb  = (src_b.size() > 0);
      bus.i_b_byte = (src_b.size() > 0) ? src_b[0] : 8'h00;
      @(negedge i_clk);
      acc_a = bus.i_a_stb && !bus.o_a_busy;
      acc_b = bus.i_b_stb && !bus.o_b_busy;
      if (chk_b_busy && src_a.size() > 0) chk("b_busy_while_a", {31'h0, bus.o_b_busy}, 32'd1);
      cyc();
      if (acc_a) void'(src_a.pop_front());
      if (acc_b) void'(src_b.pop_front());
      n++;
    end
    bus.i_a_stb = 1'b0;
    bus.i_b_stb = 1'b0;
    chk("stream_budget", {31'h0, n < 200}, 32'd1);
  endtask

  initial begin
    i_reset_n    = 1'b0;
    bus.i_a_stb  = 1'b0;
    bus.i_a_byte = 8'h00;
    bus.i_b_stb  = 1'b0;
    bus.i_b_byte = 8'h00;
    bus.i_busy   = 1'b0;
    #22;
    chk("rst_stb", {31'h0, bus.o_stb}, 32'd0);
    chk("rst_byte", {24'h0, bus.o_byte}, 32'h00);
    chk("rst_owner", {31'h0, bus.o_owner}, 32'd0);
    chk("rst_locked", {31'h0, bus.o_locked}, 32'd0);
    i_reset_n = 1'b1;
    cyc();

    // Both strobe from the start: A first, then B
    expect_byte(1'b0, 8'h52); expect_byte(1'b0, 8'h31); expect_byte(1'b0, 8'h0A);
    expect_byte(1'b1, 8'h57); expect_byte(1'b1, 8'h32); expect_byte(1'b1, 8'h0A);
    src_a = '{8'h52, 8'h31, 8'h0A};
    src_b = '{8'h57, 8'h32, 8'h0A};
    run_streams(1'b1);
    repeat (2) cyc();
    chk("t1_idle", {31'h0, bus.o_locked}, 32'd0);

    // Soft-reset preemption of A by B
    expect_byte(1'b0, 8'h41); expect_byte(1'b1, 8'h03); expect_byte(1'b1, 8'h0A);
    expect_byte(1'b0, 8'h42); expect_byte(1'b0, 8'h0A);
    bus.i_a_stb = 1'b1; bus.i_a_byte = 8'h41;
    cyc();
    chk("t2_lock_a", {31'h0, bus.o_locked}, 32'd1);
    bus.i_a_byte = 8'h42;
    bus.i_b_stb = 1'b1; bus.i_b_byte = 8'h03;
    @(negedge i_clk);
    chk("t2_a_held", {31'h0, bus.o_a_busy}, 32'd1);
    chk("t2_b_pre", {31'h0, bus.o_b_busy}, 32'd0);
    cyc();
    chk("t2_owner_b", {31'h0, bus.o_owner}, 32'd1);
    chk("t2_locked_b", {31'h0, bus.o_locked}, 32'd1);
    bus.i_b_byte = 8'h0A;
    @(negedge i_clk);
    chk("t2_a_still_held", {31'h0, bus.o_a_busy}, 32'd1);
    cyc();
    bus.i_b_stb = 1'b0;
    chk("t2_released", {31'h0, bus.o_locked}, 32'd0);
    @(negedge i_clk);
    chk("t2_a_go", {31'h0, bus.o_a_busy}, 32'd0);
    cyc();
    bus.i_a_byte = 8'h0A;
    cyc();
    bus.i_a_stb = 1'b0;
    repeat (2) cyc();

    // Idle timeout of a silent owner
    expect_byte(1'b0, 8'h55); expect_byte(1'b1, 8'h66); expect_byte(1'b1, 8'h0A);
    bus.i_a_stb = 1'b1; bus.i_a_byte = 8'h55;
    cyc();
    bus.i_a_stb = 1'b0;
    bus.i_b_stb = 1'b1; bus.i_b_byte = 8'h66;
    repeat (1023) cyc();
    chk("t3_locked_at_max", {31'h0, bus.o_locked}, 32'd1);
    @(negedge i_clk);
    chk("t3_b_waiting", {31'h0, bus.o_b_busy}, 32'd1);
    cyc();
    chk("t3_unlocked", {31'h0, bus.o_locked}, 32'd0);
    @(negedge i_clk);
    chk("t3_b_accept", {31'h0, bus.o_b_busy}, 32'd0);
    cyc();
    bus.i_b_byte = 8'h0A;
    cyc();
    bus.i_b_stb = 1'b0;
    repeat (2) cyc();

    // Owner byte arriving exactly as the counter saturates
    expect_byte(1'b0, 8'h44); expect_byte(1'b0, 8'h45);
    bus.i_a_stb = 1'b1; bus.i_a_byte = 8'h44;
    cyc();
    bus.i_a_stb = 1'b0;
    repeat (1023) cyc();
    bus.i_a_stb = 1'b1; bus.i_a_byte = 8'h45;
    cyc();
    bus.i_a_stb = 1'b0;
    chk("t4_still_locked", {31'h0, bus.o_locked}, 32'd1);
    repeat (1023) cyc();
    chk("t4_counter_restarted", {31'h0, bus.o_locked}, 32'd1);
    cyc();
    chk("t4_timeout_again", {31'h0, bus.o_locked}, 32'd0);

    // Downstream stall holds the output register
    expect_byte(1'b0, 8'h34); expect_byte(1'b0, 8'h35);
    expect_byte(1'b0, 8'h36); expect_byte(1'b0, 8'h0A);
    bus.i_a_stb = 1'b1; bus.i_a_byte = 8'h34;
    cyc();
    bus.i_a_byte = 8'h35;
    cyc();
    bus.i_busy = 1'b1;
    bus.i_a_byte = 8'h36;
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      chk("t5_stb_hold", {31'h0, bus.o_stb}, 32'd1);
      chk("t5_byte_hold", {24'h0, bus.o_byte}, 32'h35);
      chk("t5_a_busy", {31'h0, bus.o_a_busy}, 32'd1);
      chk("t5_b_busy", {31'h0, bus.o_b_busy}, 32'd1);
      cyc();
    end
    bus.i_busy = 1'b0;
    cyc();
    bus.i_a_byte = 8'h0A;
    cyc();
    bus.i_a_stb = 1'b0;
    repeat (2) cyc();

    // Asynchronous reset while a byte is pending in LOCK_B
    bus.i_b_stb = 1'b1; bus.i_b_byte = 8'h58;
    @(negedge i_clk);
    @(posedge i_clk);
    #1;
    bus.i_busy  = 1'b1;
    bus.i_b_stb = 1'b0;
    chk("t6_pending", {31'h0, bus.o_stb & bus.o_locked & bus.o_owner}, 32'd1);
    #2;
    i_reset_n = 1'b0;
    #1;
    chk("t6_rst_stb", {31'h0, bus.o_stb}, 32'd0);
    chk("t6_rst_locked", {31'h0, bus.o_locked}, 32'd0);
    chk("t6_rst_owner", {31'h0, bus.o_owner}, 32'd0);
    @(negedge i_clk);
    i_reset_n  = 1'b1;
    bus.i_busy = 1'b0;
    cyc();

    // Newlines in IDLE never lock; A wins the first tie after reset
    expect_byte(1'b0, 8'h0A); expect_byte(1'b1, 8'h0A);
    src_a = '{8'h0A};
    src_b = '{8'h0A};
    run_streams(1'b1);
    repeat (3) cyc();
    chk("t7_no_lock", {31'h0, bus.o_locked}, 32'd0);
    chk("sb_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/wbu_rxarbiter.md
Name: wbu_rxarbiter

Overview:
- Shares the single debug-bus receive path (byte stream into the printable-hex decoder) between two byte sources, A (UART RX) and B (secondary console/JTAG).
- Locks ownership to one source for a whole command line, and releases on newline or on an idle timeout.
- A soft-reset character (0x03) from the non-owner preempts the current owner, so either host can always recover the bus.
- Output is a registered stb/busy byte stream feeding the decoder directly.

Parameters:
- TIMEOUT_BITS, 10, width of the idle counter. A lock is released after 2^TIMEOUT_BITS-1 consecutive cycles with no owner byte accepted.

Ports:
- i_clk  input  1  system clock
- i_reset_n  input  1  asynchronous, active-low reset
- i_a_stb  input  1  source A byte valid
- i_a_byte  input  8  source A byte
- o_a_busy  output  1  source A stall; byte is accepted when i_a_stb && !o_a_busy
- i_b_stb  input  1  source B byte valid
- i_b_byte  input  8  source B byte
- o_b_busy  output  1  source B stall
- o_stb  output  1  output byte valid (to decoder i_stb)
- o_byte  output  8  output byte
- i_busy  input  1  downstream stall
- o_owner  output  1  current or most recent owner (0 = A, 1 = B)
- o_locked  output  1  high while in LOCK_A or LOCK_B

Behaviour:
- Clock and reset: one clock, i_clk. Reset is asynchronous and active-low on i_reset_n. All registers are cleared asynchronously.
- Reset values:
  - o_stb = 0, o_byte = 8'h00, o_owner = 0, o_locked = 0.
  - State = IDLE, last_owner = B (so A wins the first tie), idle counter = 0.
- Definitions:
  - out_ready = !o_stb || !i_busy.
  - o_stb/o_byte load only when out_ready. While o_stb && i_busy, o_stb stays 1 and o_byte is stable.
  - Latency: a byte accepted at cycle N appears on o_stb/o_byte at N+1.
  - If no byte is accepted while out_ready, o_stb <= 0.
- Combinational accept (o_x_busy = !accept_x):
  - IDLE:
    - Only one source requesting: that source is accepted if out_ready.
    - Both requesting: the source != last_owner is accepted.
  - LOCK_A: accept_a = i_a_stb && out_ready. accept_b = 1 only for preemption (below).
  - LOCK_B: symmetric to LOCK_A.
  - A byte is never accepted when !out_ready; both busy outputs are high then.
  - At most one source is accepted per cycle.
- State transitions:
  - IDLE -> LOCK_x when source x's byte is accepted. o_owner <= x, last_owner <= x, counter <= 0.
  - Exception: if that accepted byte is 8'h0A, stay in IDLE and only update last_owner and o_owner.
  - LOCK_x, owner byte 8'h0A accepted -> IDLE. The newline itself is forwarded.
  - LOCK_x, non-owner y presents a byte with i_y_byte[6:0] == 7'h03 and out_ready:
    - y's byte is accepted and forwarded; x is held busy that cycle even if requesting.
    - Next state LOCK_y, o_owner/last_owner <= y, counter <= 0.
  - LOCK_x, owner 0x03: forwarded as an ordinary byte, no state change.
  - LOCK_x, any other non-owner byte: held busy indefinitely until the lock releases.
- Idle counter (TIMEOUT_BITS wide):
  - Active in LOCK states only; forced to 0 in IDLE.
  - Cleared on each owner accept.
  - Otherwise increments each cycle, saturating at all-ones.
  - When counter == all-ones and no owner accept occurs that cycle: next state IDLE, counter 0.
  - If an owner accept occurs in the same cycle the counter reaches all-ones, the accept wins: counter is cleared and the lock is held.
  - The counter keeps running while downstream stalls (i_busy), so a stuck sink still releases the lock.
- o_locked is registered and tracks the state: 1 in LOCK_A or LOCK_B.
- Reset mid-transfer: a pending o_stb is dropped immediately and state returns to IDLE. Sources must re-present any byte they did not see accepted.

Test Plan:
- After reset, both sources strobe continuously, A sends "R1\n", B sends "W2\n", i_busy = 0:
  - A is granted first and o_byte shows 0x52, 0x31, 0x0A on consecutive cycles with o_owner = 0 and o_b_busy = 1 throughout.
  - The arbiter then returns to IDLE and B is granted next (0x57, 0x32, 0x0A), o_owner = 1.
- Lock A with 0x41, then B presents 0x03:
  - B's 0x03 appears on o_byte the next cycle.
  - o_owner = 1, o_locked = 1, and A's pending byte stays stalled until B sends 0x0A.
- Lock A, then A goes silent for 1023 cycles (TIMEOUT_BITS = 10):
  - o_locked falls on the cycle after the counter reaches 0x3FF.
  - B's waiting byte is accepted on the following cycle.
- A owner byte arrives exactly on the cycle the counter reaches 0x3FF: byte is accepted, counter returns to 0, o_locked stays 1.
- Hold i_busy = 1 for 5 cycles with o_stb = 1 and o_byte = 0x35:
  - o_stb and o_byte stay stable and both sources are busy.
  - On release, the next byte follows with no loss and no duplicate.
- Assert i_reset_n = 0 asynchronously while o_stb = 1 in LOCK_B: o_stb, o_locked and o_owner all go to 0 immediately, without waiting for a clock edge.
